// File: rtl/hsi_ccw_src.sv
// hsi_ccw_src: command-word source stage for the HSI master command path.
// Buffers one host frame, streams it byte by byte to the master, then holds
// it for retransmission until a good reply arrives or the repeats run out.
// Ports:
//   clk, n_rst          clock, synchronous active-low reset
//   abort               synchronous return to LOAD (buffer contents kept)
//   wr_en/wr_byte/wr_last, wr_rdy     host write side
//   ccw_tx_rdy/ccw_byte/ccw_rx_rdy    master byte handshake
//   ccw_accepted        pulse when the last byte of the frame was taken
//   ccw_repeat_req/reply_ok           master reply status
//   done/fail           frame outcome pulses
//   attempts            retransmissions performed for the current frame
module hsi_ccw_src #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned MAX_REPEATS = 3
) (
  input  logic                                  clk,
  input  logic                                  n_rst,
  input  logic                                  abort,
  input  logic                                  wr_en,
  input  logic [7:0]                            wr_byte,
  input  logic                                  wr_last,
  output logic                                  wr_rdy,
  output logic                                  ccw_tx_rdy,
  output logic [7:0]                            ccw_byte,
  input  logic                                  ccw_rx_rdy,
  output logic                                  ccw_accepted,
  input  logic                                  ccw_repeat_req,
  input  logic                                  reply_ok,
  output logic                                  done,
  output logic                                  fail,
  output logic [$clog2(MAX_REPEATS+1)-1:0]      attempts
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned RW = $clog2(MAX_REPEATS + 1);

  localparam logic [1:0] ST_LOAD  = 2'b00;
  localparam logic [1:0] ST_SEND  = 2'b01;
  localparam logic [1:0] ST_AWAIT = 2'b10;

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [7:0]    r_buf [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_len_m1;   // frame length minus one, fits AW bits
  logic [RW-1:0] r_attempts;
  logic          r_wr_rdy;
  logic          r_tx_rdy;
  logic          r_accepted;
  logic          r_done;
  logic          r_fail;

  logic          w_commit;
  logic          w_last_rd;
  logic          w_step_rd;
  logic          w_done;
  logic          w_fail;
  logic          w_retx;
  logic          w_write;

  // Next-state and event decode; abort overrides every transition.
  always_comb begin
    w_next    = r_state;
    w_write   = 1'b0;
    w_commit  = 1'b0;
    w_step_rd = 1'b0;
    w_last_rd = 1'b0;
    w_done    = 1'b0;
    w_fail    = 1'b0;
    w_retx    = 1'b0;
    case (r_state)
      ST_LOAD: begin
        if (wr_en) begin
          w_write = 1'b1;
          // a full buffer forces the frame boundary regardless of wr_last
          if (wr_last || (r_wr_ptr == AW'(DEPTH - 1))) begin
            w_commit = 1'b1;
            w_next   = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (ccw_rx_rdy) begin
          if (r_rd_ptr == r_len_m1) begin
            w_last_rd = 1'b1;
            w_next    = ST_AWAIT;
          end else begin
            w_step_rd = 1'b1;
          end
        end
      end
      ST_AWAIT: begin
        if (reply_ok) begin
          w_done = 1'b1;
          w_next = ST_LOAD;
        end else if (ccw_repeat_req) begin
          if (r_attempts < RW'(MAX_REPEATS)) begin
            w_retx = 1'b1;
            w_next = ST_SEND;
          end else begin
            w_fail = 1'b1;
            w_next = ST_LOAD;
          end
        end
      end
      default: w_next = ST_LOAD;
    endcase
    if (abort) begin
      w_next    = ST_LOAD;
      w_write   = 1'b0;
      w_commit  = 1'b0;
      w_step_rd = 1'b0;
      w_last_rd = 1'b0;
      w_done    = 1'b0;
      w_fail    = 1'b0;
      w_retx    = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!n_rst) r_state <= ST_LOAD;
    else        r_state <= w_next;
  end

  // Frame buffer; cleared only by reset, abort keeps its contents.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_buf[i] <= 8'h00;
    end else if (w_write) begin
      r_buf[r_wr_ptr] <= wr_byte;
    end
  end

  // Pointers, length and retransmission counter.
  always_ff @(posedge clk) begin
    if (!n_rst || abort) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_len_m1   <= '0;
      r_attempts <= '0;
    end else begin
      if (w_write)            r_wr_ptr <= AW'(r_wr_ptr + 1'b1);
      if (w_done || w_fail)   r_wr_ptr <= '0;
      if (w_commit) begin
        r_len_m1   <= r_wr_ptr;
        r_rd_ptr   <= '0;
        r_attempts <= '0;
      end
      if (w_step_rd)          r_rd_ptr <= AW'(r_rd_ptr + 1'b1);
      if (w_retx) begin
        r_rd_ptr   <= '0;
        r_attempts <= RW'(r_attempts + 1'b1);
      end
    end
  end

  // Registered status outputs decoded from the next state / events.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_wr_rdy   <= 1'b1;
      r_tx_rdy   <= 1'b0;
      r_accepted <= 1'b0;
      r_done     <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      r_wr_rdy   <= (w_next == ST_LOAD);
      r_tx_rdy   <= (w_next == ST_SEND);
      r_accepted <= w_last_rd;
      r_done     <= w_done;
      r_fail     <= w_fail;
    end
  end

  assign wr_rdy       = r_wr_rdy;
  assign ccw_tx_rdy   = r_tx_rdy;
  assign ccw_accepted = r_accepted;
  assign done         = r_done;
  assign fail         = r_fail;
  assign attempts     = r_attempts;
  assign ccw_byte     = r_buf[r_rd_ptr];

endmodule

// File: tb/tb_hsi_ccw_src.sv
// Testbench for hsi_ccw_src (DEPTH=4, MAX_REPEATS=3): expected frame bytes
// are queued when frames are loaded or retransmissions requested, and popped
// as the master side consumes them.
module tb_hsi_ccw_src;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXR  = 3;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       abort = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_byte = 8'h00;
  logic       wr_last = 1'b0;
  logic       wr_rdy;
  logic       ccw_tx_rdy;
  logic [7:0] ccw_byte;
  logic       ccw_rx_rdy = 1'b0;
  logic       ccw_accepted;
  logic       ccw_repeat_req = 1'b0;
  logic       reply_ok = 1'b0;
  logic       done;
  logic       fail;
  logic [1:0] attempts;

  int vectors = 0;
  int errors  = 0;
  logic [7:0] cur[$];
  logic [7:0] exp_q[$];

  hsi_ccw_src #(.DEPTH(DEPTH), .MAX_REPEATS(MAXR)) dut (
    .clk(clk), .n_rst(n_rst), .abort(abort),
    .wr_en(wr_en), .wr_byte(wr_byte), .wr_last(wr_last), .wr_rdy(wr_rdy),
    .ccw_tx_rdy(ccw_tx_rdy), .ccw_byte(ccw_byte), .ccw_rx_rdy(ccw_rx_rdy),
    .ccw_accepted(ccw_accepted), .ccw_repeat_req(ccw_repeat_req),
    .reply_ok(reply_ok), .done(done), .fail(fail), .attempts(attempts)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    for (int i = 0; i < cur.size() && i < int'(DEPTH); i++) exp_q.push_back(cur[i]);
  endtask

  task automatic load_frame(input bit use_last);
    for (int i = 0; i < cur.size(); i++) begin
      wr_en   = 1'b1;
      wr_byte = cur[i];
      wr_last = use_last && (i == cur.size() - 1);
      cyc();
    end
    wr_en = 1'b0; wr_last = 1'b0;
    push_frame();
    vectors++;
    if (ccw_tx_rdy !== 1'b1 || wr_rdy !== 1'b0 || attempts !== 2'd0) begin
      errors++;
      $display("FAIL load_commit tx_rdy=%b wr_rdy=%b attempts=%0d required 1 0 0",
               ccw_tx_rdy, wr_rdy, attempts);
    end
  endtask

  task automatic consume_one();
    logic [7:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty byte=%h", ccw_byte);
      e = 8'hxx;
    end else begin
      e = exp_q.pop_front();
      if (ccw_tx_rdy !== 1'b1 || ccw_byte !== e) begin
        errors++;
        $display("FAIL ccw_byte got=%h tx_rdy=%b required=%h tx_rdy=1", ccw_byte, ccw_tx_rdy, e);
      end
    end
    ccw_rx_rdy = 1'b1;
    cyc();
    ccw_rx_rdy = 1'b0;
  endtask

  task automatic xmit(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      consume_one();
      vectors++;
      if (ccw_accepted !== (i == n - 1) || ccw_tx_rdy !== (i != n - 1)) begin
        errors++;
        $display("FAIL accepted_timing byte%0d accepted=%b tx_rdy=%b required %b %b",
                 i, ccw_accepted, ccw_tx_rdy, (i == n - 1), (i != n - 1));
      end
      if (i != n - 1) repeat (gap) cyc();
    end
    cyc();
    vectors++;
    if (ccw_accepted !== 1'b0) begin
      errors++;
      $display("FAIL accepted_width got=%b required=0", ccw_accepted);
    end
  endtask

  task automatic reply_done(input logic [1:0] exp_att);
    reply_ok = 1'b1;
    cyc();
    reply_ok = 1'b0;
    vectors++;
    if (done !== 1'b1 || fail !== 1'b0 || wr_rdy !== 1'b1 || ccw_tx_rdy !== 1'b0 || attempts !== exp_att) begin
      errors++;
      $display("FAIL reply_done done=%b fail=%b wr_rdy=%b tx_rdy=%b attempts=%0d required 1 0 1 0 %0d",
               done, fail, wr_rdy, ccw_tx_rdy, attempts, exp_att);
    end
    cyc();
    vectors++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_width got=%b required=0", done);
    end
  endtask

  task automatic repeat_req(input logic [1:0] exp_att);
    ccw_repeat_req = 1'b1;
    cyc();
    ccw_repeat_req = 1'b0;
    push_frame();
    vectors++;
    if (ccw_tx_rdy !== 1'b1 || attempts !== exp_att || fail !== 1'b0) begin
      errors++;
      $display("FAIL repeat_req tx_rdy=%b attempts=%0d fail=%b required 1 %0d 0",
               ccw_tx_rdy, attempts, fail, exp_att);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) cyc();
    vectors++;
    if (wr_rdy !== 1'b1 || ccw_tx_rdy !== 1'b0 || ccw_byte !== 8'h00 || ccw_accepted !== 1'b0 ||
        done !== 1'b0 || fail !== 1'b0 || attempts !== 2'd0) begin
      errors++;
      $display("FAIL reset wr_rdy=%b tx=%b byte=%h acc=%b done=%b fail=%b att=%0d required 1 0 00 0 0 0 0",
               wr_rdy, ccw_tx_rdy, ccw_byte, ccw_accepted, done, fail, attempts);
    end
    n_rst = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    cur = '{8'hA5, 8'h5A, 8'h01};
    load_frame(1'b1);
    xmit(3, 2);
    reply_done(2'd0);
  endtask

  task automatic test_two_repeats();
    cur = '{8'h3C, 8'hC3};
    load_frame(1'b1);
    xmit(2, 0);
    repeat_req(2'd1);
    xmit(2, 1);
    repeat_req(2'd2);
    xmit(2, 0);
    reply_done(2'd2);
  endtask

  task automatic test_exhausted();
    cur = '{8'h66, 8'h99, 8'h42};
    load_frame(1'b1);
    xmit(3, 0);
    for (int r = 1; r <= int'(MAXR); r++) begin
      repeat_req(2'(r));
      xmit(3, 0);
    end
    ccw_repeat_req = 1'b1;
    cyc();
    ccw_repeat_req = 1'b0;
    vectors++;
    if (fail !== 1'b1 || done !== 1'b0 || wr_rdy !== 1'b1 || ccw_tx_rdy !== 1'b0 || attempts !== 2'd3) begin
      errors++;
      $display("FAIL exhausted fail=%b done=%b wr_rdy=%b tx=%b att=%0d required 1 0 1 0 3",
               fail, done, wr_rdy, ccw_tx_rdy, attempts);
    end
    cyc();
    vectors++;
    if (fail !== 1'b0 || attempts !== 2'd3) begin
      errors++;
      $display("FAIL fail_width_hold fail=%b att=%0d required 0 3", fail, attempts);
    end
  endtask

  task automatic test_overflow();
    cur = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    load_frame(1'b0);
    xmit(4, 0);
    reply_done(2'd0);
  endtask

  task automatic test_simultaneous();
    cur = '{8'h81, 8'h18};
    load_frame(1'b1);
    xmit(2, 0);
    ccw_repeat_req = 1'b1;
    reply_ok = 1'b1;
    cyc();
    ccw_repeat_req = 1'b0;
    reply_ok = 1'b0;
    vectors++;
    if (done !== 1'b1 || ccw_tx_rdy !== 1'b0 || wr_rdy !== 1'b1 || attempts !== 2'd0) begin
      errors++;
      $display("FAIL reply_and_repeat done=%b tx=%b wr_rdy=%b att=%0d required 1 0 1 0",
               done, ccw_tx_rdy, wr_rdy, attempts);
    end
    cyc();
    cur = '{8'hAA, 8'h55};
    load_frame(1'b1);
    consume_one();
    ccw_repeat_req = 1'b1;
    cyc();
    ccw_repeat_req = 1'b0;
    vectors++;
    if (ccw_tx_rdy !== 1'b1 || ccw_byte !== 8'h55 || attempts !== 2'd0) begin
      errors++;
      $display("FAIL repeat_in_send tx=%b byte=%h att=%0d required 1 55 0", ccw_tx_rdy, ccw_byte, attempts);
    end
    consume_one();
    vectors++;
    if (ccw_accepted !== 1'b1) begin
      errors++;
      $display("FAIL repeat_in_send_accept got=%b required=1", ccw_accepted);
    end
    reply_done(2'd0);
  endtask

  task automatic test_abort_reset();
    cur = '{8'hDE, 8'hAD, 8'hBE};
    load_frame(1'b1);
    xmit(3, 0);
    repeat_req(2'd1);
    consume_one();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    exp_q.delete();
    vectors++;
    if (ccw_tx_rdy !== 1'b0 || wr_rdy !== 1'b1 || attempts !== 2'd0 || ccw_accepted !== 1'b0 ||
        done !== 1'b0 || fail !== 1'b0 || ccw_byte !== 8'hDE) begin
      errors++;
      $display("FAIL abort tx=%b wr_rdy=%b att=%0d acc=%b done=%b fail=%b byte=%h required 0 1 0 0 0 0 de",
               ccw_tx_rdy, wr_rdy, attempts, ccw_accepted, done, fail, ccw_byte);
    end
    // abort on the final strobe suppresses ccw_accepted
    cur = '{8'h7E};
    load_frame(1'b1);
    ccw_rx_rdy = 1'b1;
    abort = 1'b1;
    cyc();
    ccw_rx_rdy = 1'b0;
    abort = 1'b0;
    exp_q.delete();
    vectors++;
    if (ccw_accepted !== 1'b0 || wr_rdy !== 1'b1 || ccw_tx_rdy !== 1'b0) begin
      errors++;
      $display("FAIL abort_last acc=%b wr_rdy=%b tx=%b required 0 1 0", ccw_accepted, wr_rdy, ccw_tx_rdy);
    end
    // one-byte frame, then abort together with reply_ok suppresses done
    load_frame(1'b1);
    xmit(1, 0);
    reply_ok = 1'b1;
    abort = 1'b1;
    cyc();
    reply_ok = 1'b0;
    abort = 1'b0;
    vectors++;
    if (done !== 1'b0 || wr_rdy !== 1'b1) begin
      errors++;
      $display("FAIL abort_reply done=%b wr_rdy=%b required 0 1", done, wr_rdy);
    end
    cur = '{8'h21, 8'h43, 8'h65};
    load_frame(1'b1);
    consume_one();
    n_rst = 1'b0;
    cyc();
    n_rst = 1'b1;
    exp_q.delete();
    vectors++;
    if (ccw_tx_rdy !== 1'b0 || wr_rdy !== 1'b1 || attempts !== 2'd0 || ccw_byte !== 8'h00 ||
        ccw_accepted !== 1'b0 || done !== 1'b0 || fail !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid tx=%b wr_rdy=%b att=%0d byte=%h acc=%b done=%b fail=%b required 0 1 0 00 0 0 0",
               ccw_tx_rdy, wr_rdy, attempts, ccw_byte, ccw_accepted, done, fail);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_two_repeats();
    test_exhausted();
    test_overflow();
    test_simultaneous();
    test_abort_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/hsi_ccw_src.md
Name: hsi_ccw_src

Overview:
Command-word source stage sitting directly upstream of the HSI master's command path.
- Host side loads one command frame of up to DEPTH bytes into a local buffer.
- Master side receives the frame byte by byte over the ccw_tx_rdy / ccw_rx_rdy handshake. The block pulses ccw_accepted when the last byte has been taken.
- The frame is held until a good reply is reported. It is retransmitted on each ccw_repeat_req, up to MAX_REPEATS times, and declared failed after that.

Parameters:
DEPTH, 16, maximum bytes per command frame (2..256); buffer index width AW = clog2(DEPTH).
MAX_REPEATS, 3, retransmissions allowed after the first transmission (1..15); counter width RW = clog2(MAX_REPEATS+1).

Ports:
clk  in  1  system clock, all logic on rising edge
n_rst  in  1  reset, synchronous, active-low
abort  in  1  synchronous clear to LOAD from any state, same effect as reset except buffer contents are kept
wr_en  in  1  host byte write strobe
wr_byte  in  8  host byte
wr_last  in  1  marks wr_byte as last byte of frame
wr_rdy  out  1  block accepts host writes (state LOAD)
ccw_tx_rdy  out  1  ccw_byte valid toward master
ccw_byte  out  8  current frame byte, buf[rd_ptr]
ccw_rx_rdy  in  1  master consumed ccw_byte (one-clk strobe)
ccw_accepted  out  1  one-clk pulse: last byte of the frame consumed
ccw_repeat_req  in  1  one-clk request to retransmit the frame
reply_ok  in  1  one-clk pulse: error-free reply frame received
done  out  1  one-clk pulse: frame completed with good reply
fail  out  1  one-clk pulse: repeats exhausted, frame dropped
attempts  out  RW  retransmissions performed for the current frame

Behaviour:
Reset values (n_rst=0 at a clock edge):
- state=LOAD; wr_ptr, rd_ptr, len, attempts = 0; buffer cleared to 0x00.
- wr_rdy=1; ccw_tx_rdy=0; ccw_byte=0x00; ccw_accepted=done=fail=0.

Registered outputs:
- ccw_tx_rdy, ccw_accepted, done, fail and wr_rdy are registered, decoded from next state.
- ccw_byte is combinational buf[rd_ptr].

LOAD:
- wr_en=1 writes buf[wr_ptr]=wr_byte and increments wr_ptr.
- If wr_last=1, or wr_ptr==DEPTH-1 (forced last, wr_last ignored): set len=wr_ptr+1, rd_ptr=0, attempts=0, go SEND.
- ccw_tx_rdy rises the cycle after the last write.
- wr_en while wr_rdy=0 is ignored; buffer is not modified.

SEND:
- ccw_tx_rdy=1.
- ccw_rx_rdy=1: if rd_ptr<len-1, rd_ptr++ and stay in SEND.
- ccw_rx_rdy=1 with rd_ptr==len-1: go AWAIT. In the next cycle ccw_tx_rdy=0 and ccw_accepted=1 for exactly one clk.
- Master gaps (ccw_rx_rdy=0) hold ccw_byte stable indefinitely.
- ccw_rx_rdy=1 while ccw_tx_rdy=0 is ignored in every state.
- 1-byte frame: the first ccw_rx_rdy goes straight to AWAIT.

AWAIT:
- reply_ok=1: done pulse, wr_ptr=0, go LOAD.
- ccw_repeat_req=1 with attempts<MAX_REPEATS: attempts++, rd_ptr=0, go SEND; the same buffer contents are resent.
- ccw_repeat_req=1 with attempts==MAX_REPEATS: fail pulse, wr_ptr=0, go LOAD.
- reply_ok and ccw_repeat_req in the same cycle: reply_ok wins (done; no retransmit).
- reply_ok / ccw_repeat_req outside AWAIT: ignored, not remembered.

attempts:
- Holds its value through LOAD until the next frame is committed, so the host can read the final count.
- Cleared at frame commit.

abort / reset mid-operation:
- abort=1 in any state: next cycle state=LOAD, wr_rdy=1, ccw_tx_rdy=0, pointers and attempts cleared.
- An in-flight ccw_accepted/done/fail is not generated.
- n_rst has priority over abort; abort has priority over all other inputs.

State encoding: LOAD=2'b00, SEND=2'b01, AWAIT=2'b10. The unused code 2'b11 returns to LOAD.

Test Plan:
1. Basic frame with gaps:
   - Stimulus: write A5, 5A, 01 (wr_last on 01); master strobes ccw_rx_rdy with 2-clk gaps.
   - Response: ccw_byte sequence A5, 5A, 01; ccw_accepted one clk after the third strobe; then reply_ok gives done=1 for one clk and wr_rdy=1.
2. Two repeats then success:
   - Stimulus: frame 3C, C3; ccw_repeat_req in AWAIT twice, each retransmission consumed; then reply_ok.
   - Response: three full transmissions of 3C, C3; ccw_accepted pulses 3 times; attempts=2; done=1; fail never asserted.
3. Repeats exhausted:
   - Stimulus: MAX_REPEATS=3; ccw_repeat_req after every transmission.
   - Response: 4 transmissions; the 4th repeat_req gives fail=1 for one clk; attempts=3; state LOAD.
4. Overflow:
   - Stimulus: DEPTH=4; write 10, 11, 12, 13, 14 with wr_last never set.
   - Response: frame commits at 13 with len=4; 14 is ignored (wr_rdy=0); transmitted bytes are 10–13.
5. Simultaneous events:
   - Stimulus: reply_ok and ccw_repeat_req in the same cycle in AWAIT.
   - Response: done=1, no retransmission.
   - Stimulus: ccw_repeat_req during SEND.
   - Response: ignored; rd_ptr unchanged.
6. Reset and abort mid-frame:
   - Stimulus: after 1 of 3 bytes consumed, assert abort; separately, assert n_rst=0.
   - Response: next cycle ccw_tx_rdy=0, wr_rdy=1, attempts=0, and no ccw_accepted/done/fail. After n_rst=0 the buffer reads 0x00, so ccw_byte=0x00.
